if_stage: RTL

- Instruction-fetch stage directly upstream of the main decoder/controller.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Latches each returned word into the instruction register and presents OP/Funct/immediate fields to the decoder.
- Computes the next PC from the decoder's NPCOp/PCWrite.
- Multi-cycle: one outstanding fetch; each instruction takes at least 2 cycles.

---
 rtl/cpu_defs_pkg.sv | 25 ++
 rtl/if_stage_npc_calc.sv | 35 +++
 rtl/if_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: next-PC select codes, fetch-stage state encoding
// and the default reset vector.
package cpu_defs;

   typedef enum logic [1:0] {
      NPC_SEQ    = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_JUMP   = 2'd2,
      NPC_JR     = 2'd3
   } npc_op_e;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_FAULT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   // A target is only legal if it lands on a word boundary.
   function automatic logic isWordAligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC selection shared by the fetch stage and the controller:
// sequential, PC-relative branch, pseudo-direct jump and register target.
module npc_calc
   import cpu_defs::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   input  logic [31:0] rs_data_i,
   input  npc_op_e     npc_op_i,
   output logic [31:0] npc_o,
   output logic [31:0] pc4_o
);

   logic [31:0] pc4;
   logic [31:0] branchOffset;
   logic [31:0] jumpTarget;

   assign pc4          = pc_i + 32'd4;
   assign branchOffset = {{14{ir_i[15]}}, ir_i[15:0], 2'b00};
   // Jump keeps the 256 MB region of the delay-slot address (PC+4), not of PC.
   assign jumpTarget   = {pc4[31:28], ir_i[25:0], 2'b00};
   assign pc4_o        = pc4;

   always_comb begin
      npc_o = pc4;
      case (npc_op_i)
         NPC_SEQ:    npc_o = pc4;
         NPC_BRANCH: npc_o = pc4 + branchOffset;
         NPC_JUMP:   npc_o = jumpTarget;
         NPC_JR:     npc_o = rs_data_i;
         default:    npc_o = pc4;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/ack handshake, holds it in IR for the decoder and retires on PCWrite.
module if_stage
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IMEM_AW  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         NPCOp,
   input  logic               PCWrite,
   input  logic               stall,
   input  logic [31:0]        rs_data,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               imem_ack,
   output logic [31:0]        PC,
   output logic [31:0]        PC4,
   output logic [31:0]        IR,
   output logic [5:0]         OP,
   output logic [5:0]         Funct,
   output logic               instr_valid,
   output logic               addr_fault,
   output logic [31:0]        retire_cnt
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ir_q, ir_d;
   logic [31:0]  retireCnt_q, retireCnt_d;
   logic [31:0]  npc;
   logic         retire;

   npc_calc uNpcCalc (
      .pc_i      (pc_q),
      .ir_i      (ir_q),
      .rs_data_i (rs_data),
      .npc_op_i  (npc_op_e'(NPCOp)),
      .npc_o     (npc),
      .pc4_o     (PC4)
   );

   // Reset is active-high and synchronous despite the port name.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= 32'd0;
         retireCnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         retireCnt_q <= retireCnt_d;
      end
   end

   assign retire = (state_q == S_EXEC) && PCWrite && !stall;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      retireCnt_d = retireCnt_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (retire) begin
               // A misaligned target still retires the instruction that produced it.
               retireCnt_d = retireCnt_q + 32'd1;
               if (isWordAligned(npc)) begin
                  pc_d    = npc;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FAULT;
               end
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase
   end

   // Request is masked during reset so memory sees no new fetch that cycle.
   always_comb begin
      imem_req    = (state_q == S_FETCH) && !rst_n;
      instr_valid = (state_q == S_EXEC);
      addr_fault  = (state_q == S_FAULT);
   end

   assign imem_addr  = IMEM_AW'(pc_q);
   assign PC         = pc_q;
   assign IR         = ir_q;
   assign OP         = ir_q[31:26];
   assign Funct      = ir_q[5:0];
   assign retire_cnt = retireCnt_q;

endmodule
